// File: rtl/seq_chunk_add.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle, LSB chunk first,
// rippling the carry between cycles through a registered carry bit.
module seq_chunk_add #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [IW-1:0]    idx;

    logic [BW-1:0]    base;
    logic [CHUNK:0]   chunk_res;
    logic             last;

    // One chunk of the ripple: current operand slice plus the stored carry.
    always_comb begin
        base      = BW'(idx) * BW'(CHUNK);
        chunk_res = {1'b0, a_r[base +: CHUNK]} + {1'b0, b_r[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry};
        last      = (idx == IW'(NCH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    sum[base +: CHUNK] <= chunk_res[CHUNK-1:0];
                    carry              <= chunk_res[CHUNK];
                    idx                <= idx + IW'(1);
                    if (last) begin
                        cout  <= chunk_res[CHUNK];
                        ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                 (chunk_res[CHUNK-1] != a_r[WIDTH-1]);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new operation.
                    if (start) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/seq_chunk_add.md
SEQ_CHUNK_ADD -- requirements
Module: seq_chunk_add

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports clk and rst_n.
REQ-002 Parameter WIDTH, default 16, SHALL set the operand and result width in bits.
REQ-003 Parameter CHUNK, default 4, SHALL set the bits added per cycle; WIDTH SHALL be a multiple of CHUNK with NCH = WIDTH/CHUNK >= 2.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  request a new operation; sampled at the rising edge.
REQ-007 sub  input  1  mode select: 0 = a+b+cin, 1 = a-b; sampled with start.
REQ-008 a  input  WIDTH  operand A; sampled with start.
REQ-009 b  input  WIDTH  operand B; sampled with start.
REQ-010 cin  input  1  carry-in, used only when sub=0; sampled with start.
REQ-011 busy  output  1  high while the chunks are being computed.
REQ-012 done  output  1  one-cycle pulse when the result is complete.
REQ-013 sum  output  WIDTH  result register.
REQ-014 cout  output  1  carry out of the MSB; in subtract mode, 1 = no borrow (a >= b unsigned).
REQ-015 ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 start SHALL be accepted at an edge where the state is IDLE or DONE; start in RUN SHALL be ignored, with no effect on operands or results.
REQ-018 On acceptance at edge k, the block SHALL:
- latch a;
- latch b' = sub ? ~b : b;
- set carry = sub ? 1 : cin;
- clear sum, cout and ovf to 0;
- set chunk index = 0;
- enter RUN.
REQ-019 In RUN, each edge SHALL compute {c, s} = a[idx chunk] + b'[idx chunk] + carry, write s into sum[idx*CHUNK +: CHUNK], set carry = c, and increment idx.
REQ-020 The chunk at idx = NCH-1 SHALL be processed at edge k+NCH; at that edge the block SHALL:
- set cout = c;
- set ovf = (a_msb == b'_msb) && (s_msb != a_msb);
- assert done;
- enter DONE.
REQ-021 busy SHALL be high exactly between edges k and k+NCH, i.e. for NCH cycles, and SHALL be low while done is high.
REQ-022 done SHALL be high for exactly one cycle, from edge k+NCH to edge k+NCH+1; DONE SHALL return to IDLE unless start is accepted, which enters RUN directly.
REQ-023 sum, cout and ovf SHALL hold their final values from done until the next accepted start.
REQ-024 While busy, sum SHALL show the chunks completed so far, with all other chunks at 0.
REQ-025 Back-to-back throughput SHALL be one result per NCH+1 cycles.
REQ-026 All arithmetic SHALL be modulo 2^WIDTH; cin SHALL be ignored when sub=1.

Reset
REQ-027 With rst_n low at an edge, the block SHALL enter IDLE and drive busy=0, done=0, sum=0, cout=0, ovf=0, with the internal carry and idx cleared.
REQ-028 Reset SHALL override start at the same edge.
REQ-029 Reset during RUN SHALL abort the operation, and no done SHALL be produced for it.

Verification (WIDTH=16, CHUNK=4, NCH=4)
REQ-030 Add: start with a=0x1234, b=0x4321, cin=0, sub=0 -> busy for 4 cycles, done at edge k+4, sum=0x5555, cout=0, ovf=0.
REQ-031 Full ripple: a=0xFFFF, b=0x0000, cin=1, sub=0 -> sum=0x0000, cout=1, ovf=0; the carry SHALL propagate through all 4 chunks.
REQ-032 Subtract and overflow:
- a=0x0003, b=0x0005, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0;
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1.
REQ-033 Abort: accept start, drive rst_n low at edge k+2 -> all outputs 0 from that edge, no done pulse; a start pulse during busy SHALL not alter the result.
REQ-034 Back-to-back: assert start during the done cycle with new operands -> busy rises at the next edge; the second done arrives 5 cycles after the first.
